// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and the prefetch queue entry type for the fetch unit
package fetch_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;
  localparam logic [WORD_W-1:0] NOP_INST = 32'h0000_0000;
  typedef struct packed {
    logic [WORD_W-1:0] inst;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: first-word-fall-through FIFO of fetch entries with wrap-around pointers; flush beats push
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_entry_t           din,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  always_ff @(posedge clk)
    if (push && !flush) r_mem[r_wp] <= din;
  always_ff @(posedge clk)
    if (flush) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(push);
      r_rp <= r_rp + AW'(pop);
      r_cnt <= r_cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign head = r_mem[r_rp];
  assign count = r_cnt;
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC/imem request generator with prefetch queue feeding IF_ID; FETCH_BYPASS_EN lets a response skip an empty queue
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          IMEM_AW     = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         imem_rd_en,
  output logic [IMEM_AW-1:0]           imem_addr,
  input  logic [31:0]                  imem_rdata,
  input  logic                         stall_flag,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         inst_valid,
  output logic [31:0]                  inst_out,
  output logic [31:0]                  pc_out,
  output logic [31:0]                  pc_plus4_out,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count
);
  logic [31:0] r_pc, r_issue_pc, r_last_pc;
  logic r_inflight;
  logic w_flush, w_ret, w_byp, w_push, w_pop, w_has;
  fetch_entry_t w_head;
  assign w_flush = reset || redirect_valid;
  assign w_ret = r_inflight && !w_flush;
`ifdef FETCH_BYPASS_EN
  assign w_byp = w_ret && queue_count == '0 && !stall_flag;
`else
  assign w_byp = 1'b0;
`endif
  assign w_has = queue_count != '0;
  assign w_push = w_ret && !w_byp;
  assign w_pop = w_has && !stall_flag && !w_flush;
  assign imem_rd_en = !w_flush && (32'(queue_count) + 32'(r_inflight)) < 32'(QUEUE_DEPTH);
  assign imem_addr = r_pc[IMEM_AW+1:2];
  assign inst_valid = w_has || w_byp;
  assign inst_out = w_byp ? imem_rdata : w_has ? w_head.inst : NOP_INST;
  assign pc_out = w_byp ? r_issue_pc : w_has ? w_head.pc : r_last_pc;
  assign pc_plus4_out = pc_out + PC_INC;
  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk  (clk),
    .flush(w_flush),
    .push (w_push),
    .pop  (w_pop),
    .din  ('{inst: imem_rdata, pc: r_issue_pc}),
    .head (w_head),
    .count(queue_count)
  );
  always_ff @(posedge clk)
    if (reset) begin
      r_pc <= RESET_PC;
      r_issue_pc <= '0;
      r_last_pc <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= imem_rd_en;
      r_last_pc <= pc_out;
      if (redirect_valid) r_pc <= redirect_pc & ~32'h3;
      else if (imem_rd_en) begin
        r_pc <= r_pc + PC_INC;
        r_issue_pc <= r_pc;
      end
    end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: table-driven and scoreboard checks of fetch_prefetch_unit streaming, stall, redirect, reset and PC wrap
module tb_fetch_prefetch_unit;
  typedef struct {
    logic        stall;
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        rd;
  } vec_t;
`ifdef FETCH_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif
  logic clk, reset, stall_flag, redirect_valid;
  logic [31:0] redirect_pc, imem_rdata, inst_out, pc_out, pc_plus4_out;
  logic imem_rd_en, inst_valid;
  logic [9:0] imem_addr;
  logic [2:0] queue_count;
  logic w_rd, w_valid;
  logic [9:0] w_addr;
  logic [31:0] w_rdata, w_inst, w_pc, w_pc4;
  logic [2:0] w_cnt;
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  vec_t tbl[11];
  fetch_prefetch_unit dut (
    .clk(clk), .reset(reset), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .stall_flag(stall_flag), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_out(inst_out),
    .pc_out(pc_out), .pc_plus4_out(pc_plus4_out), .queue_count(queue_count)
  );
  fetch_prefetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .reset(reset), .imem_rd_en(w_rd), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .stall_flag(1'b0), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .inst_valid(w_valid), .inst_out(w_inst),
    .pc_out(w_pc), .pc_plus4_out(w_pc4), .queue_count(w_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    imem_rdata <= 32'(imem_addr) + 32'd100;
    w_rdata <= 32'(w_addr) + 32'd100;
  end
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'(pc[11:2]) + 32'd100;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask
  task automatic stream(input int n, input logic [31:0] start, output int lat);
    int got = 0;
    int cyc = 0;
    logic [31:0] e;
    lat = -1;
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    while (got < n) begin
      if (inst_valid) begin
        if (lat < 0) lat = cyc;
        e = exp_q.pop_front();
        chk("stream_pc", pc_out, e);
        chk("stream_inst", inst_out, inst_of(e));
        chk("stream_pc4", pc_plus4_out, e + 32'd4);
        got++;
      end else if (lat >= 0) chk("one_per_cycle", 32'(inst_valid), 32'd1);
      if (cyc > n + 12) begin
        chk("stream_timeout", 32'(got), 32'(n));
        exp_q.delete();
        break;
      end
      cyc++;
      next_cycle();
    end
  endtask
  task automatic wrap_check();
    logic [9:0] ea[3];
    logic [31:0] ep[3];
    int nv = 0;
    ea = '{10'd1022, 10'd1023, 10'd0};
    ep = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    for (int k = 0; k < 7; k++) begin
      if (k < 3) chk("wrap_addr", 32'(w_addr), 32'(ea[k]));
      if (w_valid && nv < 3) begin
        chk("wrap_pc", w_pc, ep[nv]);
        chk("wrap_inst", w_inst, 32'(ea[nv]) + 32'd100);
        nv++;
      end
      next_cycle();
    end
    chk("wrap_count", 32'(nv), 32'd3);
  endtask
  task automatic chk_restart(input string tag, input logic [9:0] addr);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_count"}, 32'(queue_count), 32'd0);
    chk({tag, "_rd"}, 32'(imem_rd_en), 32'd1);
    chk({tag, "_addr"}, 32'(imem_addr), 32'(addr));
  endtask
  initial begin
    int lat, w;
    tbl[0]  = '{1'b1, 1'b1, 32'h00, 3'd1, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 32'h00, 3'd2, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 32'h00, 3'd3, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 32'h00, 3'd4, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 32'h00, 3'd4, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 32'h00, 3'd4, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h00, 3'd4, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 32'h04, 3'd3, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 32'h08, 3'd2, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 32'h0C, 3'd2, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 32'h10, 3'd2, 1'b1};
    reset = 1'b1;
    stall_flag = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst_out, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_pc4", pc_plus4_out, 32'd4);
    chk("rst_count", 32'(queue_count), 32'd0);
    chk("rst_rd", 32'(imem_rd_en), 32'd0);
    reset = 1'b0;
    #1;
    fork
      stream(8, 32'h0, lat);
      wrap_check();
    join
    chk("first_valid_lat", 32'(lat), 32'(EXP_LAT));
    reset = 1'b1;
    stall_flag = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    next_cycle();
    next_cycle();
    for (int i = 0; i < 11; i++) begin
      stall_flag = tbl[i].stall;
      #1;
      chk("tbl_valid", 32'(inst_valid), 32'(tbl[i].valid));
      chk("tbl_pc", pc_out, tbl[i].pc);
      chk("tbl_inst", inst_out, inst_of(tbl[i].pc));
      chk("tbl_count", 32'(queue_count), 32'(tbl[i].cnt));
      chk("tbl_rd", 32'(imem_rd_en), 32'(tbl[i].rd));
      next_cycle();
    end
    stream(4, 32'h14, lat);
    reset = 1'b1;
    stall_flag = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    w = 0;
    while (queue_count != 3'd3 && w < 10) begin
      next_cycle();
      w++;
    end
    chk("q3_reach", 32'(queue_count), 32'd3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    stall_flag = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk_restart("redir", 10'd16);
    stream(6, 32'h40, lat);
    redirect_valid = 1'b1;
    redirect_pc = 32'h83;
    stall_flag = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    stall_flag = 1'b0;
    #1;
    chk_restart("redir_stall", 10'd32);
    stream(5, 32'h80, lat);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_restart("mid_rst", 10'd0);
    chk("mid_rst_inst", inst_out, 32'd0);
    chk("mid_rst_pc", pc_out, 32'd0);
    chk("mid_rst_pc4", pc_plus4_out, 32'd4);
    stream(4, 32'h0, lat);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
